// File: rtl/apb_pkg.sv
// Shared APB types, error codes and address helpers for the APB master and completer.
package apb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_slv_state_t;

   typedef enum logic [1:0] {MST_IDLE, MST_SETUP, MST_ACCESS} apb_mst_state_t;

   localparam logic [2:0] APB_ERR_NONE     = 3'd0;
   localparam logic [2:0] APB_ERR_MISALIGN = 3'd1;
   localparam logic [2:0] APB_ERR_RANGE    = 3'd2;
   localparam logic [2:0] APB_ERR_RDONLY   = 3'd3;
   localparam logic [2:0] APB_ERR_STRB     = 3'd4;
   localparam logic [2:0] APB_ERR_PROTO    = 3'd5;

   localparam logic [31:0] APB_ID_DEFAULT = 32'hA9B0_0001;

   // Byte address to 32-bit word index; callers zero-extend paddr to 64 bits.
   function automatic logic [63:0] word_idx(input logic [63:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// Register storage for the APB completer: byte-enabled write port, combinational read port.
module apb_slv_regbank #(
   parameter int unsigned       NUM_REGS  = 16,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       IDX_W     = 4,
   parameter logic [DATA_W-1:0] WORD0_RST = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= (i == 0) ? WORD0_RST : '0;
         end
      end else if (we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file and programmable wait states.
// Optional byte strobes (pstrb) are enabled by defining APB_SLV_PSTRB_EN.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       NUM_REGS    = 16,
   parameter int unsigned       WAIT_CYCLES = 1,
   parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(APB_ID_DEFAULT)
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_W/8-1:0] pstrb,
`endif
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned BE_W  = DATA_W / 8;

   apb_slv_state_t    state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_cur;
   logic              write_q, write_cur;
   logic [DATA_W-1:0] wdata_q, wdata_cur;
   logic [BE_W-1:0]   be_q, be_cur, be_in;
   logic [2:0]        err_code_q, err_code_d, err_cur;
   logic [63:0]       addr_ext, widx;
   logic              proto_err, go_access, resp_err, we;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      addr_ext = 64'(paddr);
      widx     = word_idx(addr_ext);
`ifdef APB_SLV_PSTRB_EN
      be_in    = pstrb;
`else
      be_in    = '1;
`endif
   end

   always_comb begin
      err_code_d = APB_ERR_NONE;
      if (paddr[1:0] != 2'b00) begin
         err_code_d = APB_ERR_MISALIGN;
      end else if (widx >= 64'(NUM_REGS)) begin
         err_code_d = APB_ERR_RANGE;
      end else if (pwrite && (widx == 64'd0)) begin
         err_code_d = APB_ERR_RDONLY;
`ifdef APB_SLV_PSTRB_EN
      end else if (!pwrite && (|pstrb)) begin
         err_code_d = APB_ERR_STRB;
`endif
      end
   end

   // While in SETUP the live bus is the value being latched; a zero-wait access uses it directly.
   always_comb begin
      if (state_q == SETUP) begin
         idx_cur   = widx[IDX_W-1:0];
         write_cur = pwrite;
         wdata_cur = pwdata;
         be_cur    = be_in;
         err_cur   = err_code_d;
      end else begin
         idx_cur   = idx_q;
         write_cur = write_q;
         wdata_cur = wdata_q;
         be_cur    = be_q;
         err_cur   = err_code_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      proto_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = SETUP;
            end else if (psel && penable) begin
               state_d   = ACCESS;
               proto_err = 1'b1;
            end
         end
         SETUP: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         WAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            state_d = (psel && !penable) ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Response and commit happen on the edge that enters ACCESS.
   assign go_access = (state_d == ACCESS);
   assign resp_err  = proto_err || (err_cur != APB_ERR_NONE);
   assign we        = go_access && !resp_err && write_cur;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         err_code_q <= APB_ERR_NONE;
         prdata     <= '0;
         pready     <= 1'b0;
         pslverr    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == SETUP) begin
            idx_q      <= idx_cur;
            write_q    <= write_cur;
            wdata_q    <= wdata_cur;
            be_q       <= be_cur;
            err_code_q <= err_cur;
         end
         pready  <= go_access;
         pslverr <= go_access && resp_err;
         prdata  <= (go_access && !resp_err && !write_cur) ? rdata : '0;
      end
   end

   apb_slv_regbank #(
      .NUM_REGS  (NUM_REGS),
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W),
      .WORD0_RST (ID_VALUE)
   ) u_regbank (
      .clk   (pclk),
      .rst   (preset),
      .we    (we),
      .be    (be_cur),
      .idx   (idx_cur),
      .wdata (wdata_cur),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: one instance with one wait state, one with none.
module tb_apb_slave_regfile;

   localparam int unsigned NUM_REGS = 16;
   localparam logic [31:0] ID       = 32'hA9B0_0001;

   logic        pclk = 1'b0;
   logic        preset, psel, penable, pwrite, sel;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic        psel_a, psel_b;
   logic [31:0] prdata_a, prdata_b, cur_prdata;
   logic        pready_a, pready_b, pslverr_a, pslverr_b, cur_pready, cur_pslverr;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] mdl [2][NUM_REGS];

   assign psel_a      = psel & ~sel;
   assign psel_b      = psel & sel;
   assign cur_prdata  = sel ? prdata_b : prdata_a;
   assign cur_pready  = sel ? pready_b : pready_a;
   assign cur_pslverr = sel ? pslverr_b : pslverr_a;

   always #5 pclk = ~pclk;

   apb_slave_regfile #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(1)) u_dut_a (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_a),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_a),
      .pready  (pready_a),
      .pslverr (pslverr_a)
   );

   apb_slave_regfile #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(0)) u_dut_b (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_b),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_b),
      .pready  (pready_b),
      .pslverr (pslverr_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mdl[d][i] = (i == 0) ? ID : 32'h0;
         end
      end
   endfunction

   task automatic model_xfer(input int d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             output bit err, output logic [31:0] rd);
      int unsigned w;
      logic [3:0]  lanes;
      w = addr / 4;
`ifdef APB_SLV_PSTRB_EN
      lanes = strb;
`else
      lanes = 4'hF;
`endif
      err = (addr % 4 != 0) || (w >= NUM_REGS) || (wr && w == 0);
`ifdef APB_SLV_PSTRB_EN
      if (!wr && strb != 4'h0) err = 1'b1;
`endif
      rd = 32'h0;
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (lanes[b]) mdl[d][w][8*b +: 8] = data[8*b +: 8];
            end
         end else begin
            rd = mdl[d][w];
         end
      end
   endtask

   task automatic idle();
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
   endtask

   // Setup phase, access phase, then hold until pready; address/data are scrambled during waits.
   task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat, output logic [31:0] rd,
                           output logic err);
      bit done;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      lat  = 0;
      rd   = 32'h0;
      err  = 1'b0;
      done = 1'b0;
      for (int i = 1; i <= 40 && !done; i++) begin
         @(posedge pclk);
         #1;
         if (cur_pready) begin
            lat  = i;
            rd   = cur_prdata;
            err  = cur_pslverr;
            done = 1'b1;
         end else begin
            paddr  = $urandom;
            pwdata = $urandom;
            pwrite = 1'($urandom);
            pstrb  = 4'($urandom);
         end
      end
   endtask

   task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit b2b, input string tag);
      bit          eerr;
      logic [31:0] erd, rd;
      logic        err;
      int          lat;
      model_xfer(int'(sel), wr, addr, data, strb, eerr, erd);
      apb_xfer(wr, addr, data, strb, lat, rd, err);
      check({tag, ".lat"}, lat, sel ? 32'd1 : 32'd2);
      check({tag, ".err"}, 32'(err), 32'(eerr));
      if (!wr) check({tag, ".rdata"}, rd, erd);
      if (!b2b) begin
         idle();
         check({tag, ".drop"}, 32'(cur_pready), 32'd0);
      end
   endtask

   initial begin
      bit          b2b, prev_b2b;
      bit          wr;
      logic [31:0] addr, data;
      logic [3:0]  strb;
      int unsigned r;

      sel     = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      preset  = 1'b1;
      model_reset();
      repeat (3) @(posedge pclk);
      #1;
      check("rst.a.pready", 32'(pready_a), 32'd0);
      check("rst.a.pslverr", 32'(pslverr_a), 32'd0);
      check("rst.a.prdata", prdata_a, 32'h0);
      check("rst.b.pready", 32'(pready_b), 32'd0);
      check("rst.b.pslverr", 32'(pslverr_b), 32'd0);
      check("rst.b.prdata", prdata_b, 32'h0);
      preset = 1'b0;
      idle();

      // One wait state: basic write/read, read-only ID, out-of-range and misaligned.
      sel = 1'b0;
      do_xfer(1'b1, 32'h08, 32'h1234_5678, 4'hF, 1'b0, "wr08");
      do_xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, "rd08");
      do_xfer(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, "rd00");
      do_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr00");
      do_xfer(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, "rd00b");
      do_xfer(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, "wr40");
      do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, "rd40");
      do_xfer(1'b1, 32'h06, 32'hBAD0_BAD0, 4'hF, 1'b0, "wr06");
      do_xfer(1'b0, 32'h06, 32'h0, 4'h0, 1'b0, "rd06");
      do_xfer(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, "rd04");
      do_xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, "rd08b");

      // Zero wait states, back-to-back writes with no idle cycle between them.
      sel = 1'b1;
      do_xfer(1'b1, 32'h04, 32'h1111_2222, 4'hF, 1'b1, "b2b04");
      do_xfer(1'b1, 32'h0C, 32'h3333_4444, 4'hF, 1'b0, "b2b0c");
      do_xfer(1'b0, 32'h04, 32'h0, 4'h0, 1'b1, "b2brd04");
      do_xfer(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, "b2brd0c");

      // Access phase without a setup phase.
      sel     = 1'b0;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h08;
      pwdata  = 32'h0000_0055;
      pstrb   = 4'hF;
      @(posedge pclk);
      #1;
      check("proto.pready", 32'(cur_pready), 32'd1);
      check("proto.pslverr", 32'(cur_pslverr), 32'd1);
      check("proto.prdata", cur_prdata, 32'h0);
      idle();
      check("proto.drop", 32'(cur_pready), 32'd0);
      do_xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, "proto.rd08");

      // Reset while a write sits in WAIT.
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'hDEAD_BEEF;
      pstrb   = 4'hF;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      @(posedge pclk);
      #1;
      check("rstwait.pready0", 32'(cur_pready), 32'd0);
      preset = 1'b1;
      @(posedge pclk);
      #1;
      check("rstwait.pready1", 32'(cur_pready), 32'd0);
      preset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      model_reset();
      idle();
      check("rstwait.pready2", 32'(cur_pready), 32'd0);
      do_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rstwait.rd10");
      do_xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, "rstwait.rd08");
      do_xfer(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, "rstwait.rd00");

`ifdef APB_SLV_PSTRB_EN
      do_xfer(1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b0, "strb.wr14");
      do_xfer(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "strb.rd14");
      do_xfer(1'b0, 32'h14, 32'h0, 4'h3, 1'b0, "strb.rderr");
`endif

      prev_b2b = 1'b0;
      for (int k = 0; k < 150; k++) begin
         if (!prev_b2b) sel = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         if (r < 7) begin
            addr = 32'(4 * $urandom_range(0, NUM_REGS - 1));
         end else if (r == 7) begin
            addr = 32'(4 * $urandom_range(0, NUM_REGS - 1) + $urandom_range(1, 3));
         end else if (r == 8) begin
            addr = 32'(4 * $urandom_range(NUM_REGS, 63));
         end else begin
            addr = (32'd1 << $urandom_range(6, 31)) | 32'(4 * $urandom_range(0, NUM_REGS - 1));
         end
         data = $urandom;
         if (wr) strb = 4'($urandom);
         else    strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         b2b  = ($urandom_range(0, 3) == 0) && (k < 149);
         do_xfer(wr, addr, data, strb, b2b, "rand");
         prev_b2b = b2b;
      end

      for (int i = 0; i < NUM_REGS; i++) begin
         sel = 1'b0;
         do_xfer(1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b0, "final.a");
         sel = 1'b1;
         do_xfer(1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b0, "final.b");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
